piece_dispatch: RTL and testbench

PIECE_DISPATCH -- requirements
Module: piece_dispatch

---
 rtl/piece_dispatch.sv | 152 +++++++++++++++
 tb/tb_piece_dispatch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_dispatch.sv
// Piece dispatcher: drives the block queue (shift/swap pulses), waits for the
// queue outputs to settle, then presents the next active piece at the spawn point.
module piece_dispatch #(
    parameter int SETTLE    = 2,
    parameter int SPAWN_X   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spawn_req,
    input  logic       hold_req,
    input  logic [2:0] queue_out,
    input  logic [2:0] queue_hold,
    output logic       shift_right,
    output logic       swap,
    output logic       piece_valid,
    output logic [2:0] piece_type,
    output logic [3:0] spawn_x,
    output logic [4:0] spawn_y,
    output logic       hold_used,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SWAP,
        SETTLE_WAIT,
        LOAD,
        ACTIVE,
        ERR
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] SPAWN_COL   = 4'(SPAWN_X);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] retry_cnt;
    logic       pending_shift;
    logic [2:0] retry_inc;

    assign retry_inc = {1'b0, retry_cnt} + 3'd1;

    // Spawn row is always the top of the playfield.
    assign spawn_y = '0;

    // NOTE: non-blocking assignments throughout, so every register here samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            retry_cnt     <= '0;
            pending_shift <= 1'b0;
            shift_right   <= 1'b0;
            swap          <= 1'b0;
            piece_valid   <= 1'b0;
            piece_type    <= '0;
            spawn_x       <= '0;
            hold_used     <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
        end else begin
            shift_right <= 1'b0;
            swap        <= 1'b0;

            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        state         <= SHIFT;
                        shift_right   <= 1'b1;
                        pending_shift <= 1'b0;
                        busy          <= 1'b1;
                    end
                end

                SHIFT, SWAP: begin
                    state      <= SETTLE_WAIT;
                    settle_cnt <= '0;
                end

                SETTLE_WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        if (pending_shift) begin
                            // Hold slot was empty: the swap must be followed by a shift.
                            state         <= SHIFT;
                            shift_right   <= 1'b1;
                            pending_shift <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                LOAD: begin
                    if (queue_out != 3'd0) begin
                        state       <= ACTIVE;
                        piece_type  <= queue_out;
                        retry_cnt   <= '0;
                        piece_valid <= 1'b1;
                        spawn_x     <= SPAWN_COL;
                        busy        <= 1'b0;
                    end else if (retry_inc == RETRY_LIMIT) begin
                        state     <= ERR;
                        retry_cnt <= retry_inc[1:0];
                        error     <= 1'b1;
                    end else begin
                        state         <= SHIFT;
                        retry_cnt     <= retry_inc[1:0];
                        shift_right   <= 1'b1;
                        pending_shift <= 1'b0;
                    end
                end

                ACTIVE: begin
                    // A spawn request takes priority over a simultaneous hold.
                    if (spawn_req) begin
                        state         <= SHIFT;
                        shift_right   <= 1'b1;
                        pending_shift <= 1'b0;
                        hold_used     <= 1'b0;
                        piece_valid   <= 1'b0;
                        spawn_x       <= '0;
                        busy          <= 1'b1;
                    end else if (hold_req && !hold_used) begin
                        state         <= SWAP;
                        swap          <= 1'b1;
                        pending_shift <= (queue_hold == 3'd0);
                        hold_used     <= 1'b1;
                        piece_valid   <= 1'b0;
                        spawn_x       <= '0;
                        busy          <= 1'b1;
                    end
                end

                ERR: begin
                    state <= ERR;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_dispatch.sv
// Directed bench for piece_dispatch: spawn, hold with full/empty hold slot,
// spawn/hold collision, empty-queue error and reset during settle.
module tb_piece_dispatch;

    localparam int SETTLE    = 2;
    localparam int SPAWN_X   = 4;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       spawn_req;
    logic       hold_req;
    logic [2:0] queue_out;
    logic [2:0] queue_hold;
    logic       shift_right;
    logic       swap;
    logic       piece_valid;
    logic [2:0] piece_type;
    logic [3:0] spawn_x;
    logic [4:0] spawn_y;
    logic       hold_used;
    logic       busy;
    logic       error;

    int checks = 0;
    int errors = 0;

    piece_dispatch #(
        .SETTLE   (SETTLE),
        .SPAWN_X  (SPAWN_X),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spawn_req  (spawn_req),
        .hold_req   (hold_req),
        .queue_out  (queue_out),
        .queue_hold (queue_hold),
        .shift_right(shift_right),
        .swap       (swap),
        .piece_valid(piece_valid),
        .piece_type (piece_type),
        .spawn_x    (spawn_x),
        .spawn_y    (spawn_y),
        .hold_used  (hold_used),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until piece_valid is seen or the budget expires (cyc stays -1).
    // Requests set by the caller are dropped after the first edge.
    task automatic run_until_valid(input int budget, output int cyc, output int n_shift,
                                   output int n_swap, output int first_shift,
                                   output int first_swap, output int overlap);
        cyc = -1; n_shift = 0; n_swap = 0; first_shift = -1; first_swap = -1; overlap = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (i == 1) begin
                spawn_req = 1'b0;
                hold_req  = 1'b0;
            end
            if (shift_right && swap) overlap++;
            if (shift_right) begin
                n_shift++;
                if (first_shift < 0) first_shift = i;
            end
            if (swap) begin
                n_swap++;
                if (first_swap < 0) first_swap = i;
            end
            if (piece_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Counts pulses over a fixed window with no new requests.
    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            spawn_req = 1'b0;
            hold_req  = 1'b0;
            if (shift_right) pulses++;
            if (swap) pulses++;
        end
    endtask

    int cyc, n_shift, n_swap, f_shift, f_swap, ovl, pulses;

    initial begin
        reset      = 1'b1;
        spawn_req  = 1'b0;
        hold_req   = 1'b0;
        queue_out  = 3'd5;
        queue_hold = 3'd3;
        step();
        step();
        check("rst_piece_valid", piece_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_piece_type", piece_type, 0);
        check("rst_spawn_x", spawn_x, 0);
        reset = 1'b0;

        count_pulses(4, pulses);
        check("idle_no_pulse", pulses, 0);

        // Basic spawn from IDLE.
        spawn_req = 1'b1;
        run_until_valid(30, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("spawn_latency", cyc, SETTLE + 3);
        check("spawn_shift_cnt", n_shift, 1);
        check("spawn_swap_cnt", n_swap, 0);
        check("spawn_type", piece_type, 5);
        check("spawn_x", spawn_x, SPAWN_X);
        check("spawn_y", spawn_y, 0);
        check("spawn_busy", busy, 0);
        check("spawn_hold_used", hold_used, 0);

        // Hold with a non-empty hold slot: a single swap, then load.
        queue_hold = 3'd3;
        queue_out  = 3'd3;
        hold_req   = 1'b1;
        run_until_valid(30, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("hold_latency", cyc, SETTLE + 3);
        check("hold_swap_cnt", n_swap, 1);
        check("hold_shift_cnt", n_shift, 0);
        check("hold_used_set", hold_used, 1);
        check("hold_type", piece_type, 3);

        // Second hold in the same drop is ignored.
        hold_req = 1'b1;
        count_pulses(6, pulses);
        check("hold2_no_pulse", pulses, 0);
        check("hold2_valid", piece_valid, 1);
        check("hold2_busy", busy, 0);

        // New drop clears hold_used.
        queue_out = 3'd6;
        spawn_req = 1'b1;
        run_until_valid(30, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("spawn2_type", piece_type, 6);
        check("spawn2_hold_used", hold_used, 0);

        // Spawn and hold together: spawn wins.
        queue_out = 3'd2;
        spawn_req = 1'b1;
        hold_req  = 1'b1;
        run_until_valid(30, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("both_latency", cyc, SETTLE + 3);
        check("both_shift_cnt", n_shift, 1);
        check("both_swap_cnt", n_swap, 0);
        check("both_hold_used", hold_used, 0);
        check("both_type", piece_type, 2);

        // Hold with an empty hold slot: swap, settle gap, shift, load.
        queue_hold = 3'd0;
        queue_out  = 3'd7;
        hold_req   = 1'b1;
        run_until_valid(40, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("empty_hold_latency", cyc, 2 * SETTLE + 4);
        check("empty_hold_swap_cnt", n_swap, 1);
        check("empty_hold_shift_cnt", n_shift, 1);
        check("empty_hold_first_swap", f_swap, 1);
        check("empty_hold_gap", f_shift - f_swap - 1, SETTLE);
        check("empty_hold_overlap", ovl, 0);
        check("empty_hold_used", hold_used, 1);
        check("empty_hold_type", piece_type, 7);

        // Reset while settling after a swap.
        queue_out = 3'd4;
        spawn_req = 1'b1;
        run_until_valid(30, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("pre_rst_type", piece_type, 4);
        queue_hold = 3'd3;
        hold_req   = 1'b1;
        step();
        hold_req = 1'b0;
        check("pre_rst_swap", swap, 1);
        step();
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hold_used", hold_used, 0);
        check("mid_rst_type", piece_type, 0);
        check("mid_rst_pulses", {shift_right, swap}, 0);
        step();
        step();
        reset = 1'b0;
        count_pulses(5, pulses);
        check("post_rst_no_pulse", pulses, 0);
        queue_out = 3'd5;
        spawn_req = 1'b1;
        run_until_valid(30, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("post_rst_latency", cyc, SETTLE + 3);
        check("post_rst_shift_cnt", n_shift, 1);
        check("post_rst_type", piece_type, 5);

        // Empty queue: MAX_RETRY shifts, then a sticky error.
        queue_out = 3'd0;
        spawn_req = 1'b1;
        run_until_valid(40, cyc, n_shift, n_swap, f_shift, f_swap, ovl);
        check("err_no_valid", cyc, -1);
        check("err_shift_cnt", n_shift, MAX_RETRY);
        check("err_flag", error, 1);
        check("err_busy", busy, 1);
        queue_out = 3'd5;
        spawn_req = 1'b1;
        hold_req  = 1'b1;
        count_pulses(10, pulses);
        check("err_stuck_pulses", pulses, 0);
        check("err_stuck_flag", error, 1);
        check("err_stuck_valid", piece_valid, 0);
        reset = 1'b1;
        #1;
        check("err_rst_flag", error, 0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
